// File: rtl/ee354_numlock_ctrl.sv
// Button conditioner and retry-lockout controller sitting in front of the numlock state machine.
// Optional idle-abort path is enabled by defining NUMLOCK_CTRL_IDLE_ABORT_EN.
module ee354_numlock_ctrl #(
  parameter int DEB_CYCLES     = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int IDLE_CYCLES    = 32
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       BtnU,
  input  logic       BtnZ,
  input  logic       q_Bad,
  input  logic       q_Opening,
  output logic       U,
  output logic       Z,
  output logic       sm_reset,
  output logic       Locked,
  output logic       Conflict,
  output logic [2:0] fail_cnt
);

  localparam logic [7:0]  DEB_LAST  = 8'(DEB_CYCLES - 1);
  localparam logic [2:0]  FAIL_MAX  = 3'(MAX_FAILS);
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);

  generate
    if (DEB_CYCLES < 1 || DEB_CYCLES > 255 || MAX_FAILS < 1 || MAX_FAILS > 7 ||
        LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > 65535 ||
        IDLE_CYCLES < 1 || IDLE_CYCLES > 65535) begin : g_param_check
      $error("ee354_numlock_ctrl: parameter out of range");
    end
  endgenerate

  // Bit 0 is the "1" button, bit 1 the "0" button.
  logic [1:0] raw_btn;
  logic [1:0] db_level;
  assign raw_btn = {BtnZ, BtnU};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic       sync1_reg;
      logic       sync2_reg;
      logic       db_reg;
      logic [7:0] cnt_reg;

      always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          db_reg    <= 1'b0;
          cnt_reg   <= 8'd0;
        end else begin
          sync1_reg <= raw_btn[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg != db_reg) begin
            if (cnt_reg == DEB_LAST) begin
              db_reg  <= sync2_reg;
              cnt_reg <= 8'd0;
            end else begin
              cnt_reg <= cnt_reg + 8'd1;
            end
          end else begin
            cnt_reg <= 8'd0;
          end
        end
      end

      assign db_level[gi] = db_reg;
    end
  endgenerate

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LOCKOUT = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] lock_cnt_reg;
  logic        q_bad_d_reg;
  logic        q_open_d_reg;
  // Buttons still held when leaving CLEAR stay blocked until seen released.
  logic [1:0]  mask_reg;
  logic        bad_rise;
  logic        open_rise;

  assign bad_rise  = q_Bad & ~q_bad_d_reg;
  assign open_rise = q_Opening & ~q_open_d_reg;

`ifdef NUMLOCK_CTRL_IDLE_ABORT_EN
  localparam logic [15:0] IDLE_LAST = 16'(IDLE_CYCLES - 1);
  logic [15:0] idle_cnt_reg;
  logic        pressed_reg;
`endif

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      lock_cnt_reg <= 16'd0;
      q_bad_d_reg  <= 1'b0;
      q_open_d_reg <= 1'b0;
      mask_reg     <= 2'b00;
      U            <= 1'b0;
      Z            <= 1'b0;
      sm_reset     <= 1'b0;
      Locked       <= 1'b0;
      Conflict     <= 1'b0;
      fail_cnt     <= 3'd0;
`ifdef NUMLOCK_CTRL_IDLE_ABORT_EN
      idle_cnt_reg <= 16'd0;
      pressed_reg  <= 1'b0;
`endif
    end else begin
      q_bad_d_reg  <= q_Bad;
      q_open_d_reg <= q_Opening;
      Conflict     <= &db_level;
      U            <= 1'b0;
      Z            <= 1'b0;
      sm_reset     <= 1'b0;

      case (state_reg)
        RUN: begin
          U        <= db_level[0] & ~db_level[1] & ~mask_reg[0];
          Z        <= db_level[1] & ~db_level[0] & ~mask_reg[1];
          mask_reg <= mask_reg & db_level;
          if (fail_cnt == FAIL_MAX) begin
            state_reg    <= LOCKOUT;
            lock_cnt_reg <= LOCK_LAST;
            Locked       <= 1'b1;
          end else begin
            if (open_rise) begin
              fail_cnt <= 3'd0;
            end else if (bad_rise && fail_cnt < FAIL_MAX) begin
              fail_cnt <= fail_cnt + 3'd1;
            end
`ifdef NUMLOCK_CTRL_IDLE_ABORT_EN
            if (|db_level) begin
              idle_cnt_reg <= 16'd0;
              pressed_reg  <= 1'b1;
            end else if (pressed_reg) begin
              if (idle_cnt_reg == IDLE_LAST) begin
                state_reg    <= CLEAR;
                sm_reset     <= 1'b1;
                idle_cnt_reg <= 16'd0;
                pressed_reg  <= 1'b0;
              end else begin
                idle_cnt_reg <= idle_cnt_reg + 16'd1;
              end
            end
`endif
          end
        end

        LOCKOUT: begin
          if (lock_cnt_reg == 16'd0) begin
            state_reg <= CLEAR;
            Locked    <= 1'b0;
            sm_reset  <= 1'b1;
            fail_cnt  <= 3'd0;
`ifdef NUMLOCK_CTRL_IDLE_ABORT_EN
            idle_cnt_reg <= 16'd0;
            pressed_reg  <= 1'b0;
`endif
          end else begin
            lock_cnt_reg <= lock_cnt_reg - 16'd1;
          end
        end

        CLEAR: begin
          mask_reg  <= db_level;
          state_reg <= RUN;
        end

        default: begin
          state_reg <= RUN;
          Locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ee354_numlock_ctrl.sv
// Self-checking bench for ee354_numlock_ctrl with default parameters.
// Expected sm_reset count in the idle test depends on NUMLOCK_CTRL_IDLE_ABORT_EN.
module tb_ee354_numlock_ctrl;

  localparam int MAXF = 3;
  localparam int LAT  = 7;   // 2 sync + 4 debounce + 1 output register

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       BtnU = 1'b0;
  logic       BtnZ = 1'b0;
  logic       q_Bad = 1'b0;
  logic       q_Opening = 1'b0;
  logic       U, Z, sm_reset, Locked, Conflict;
  logic [2:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  ee354_numlock_ctrl dut (
    .Clk(Clk), .reset(reset), .BtnU(BtnU), .BtnZ(BtnZ),
    .q_Bad(q_Bad), .q_Opening(q_Opening),
    .U(U), .Z(Z), .sm_reset(sm_reset), .Locked(Locked),
    .Conflict(Conflict), .fail_cnt(fail_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic bu, bz, qb, qo;
    int   hold;
    logic eu, ez, ec, el;
    int   ef;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse(input logic b, input logic o);
    q_Bad = b;
    q_Opening = o;
    tick(1);
    q_Bad = 1'b0;
    q_Opening = 1'b0;
    tick(1);
  endtask

  // Called right after the pulse that pushed the count to the limit.
  task automatic expect_lockout(input string tag);
    int lk;
    int sr;
    lk = int'(Locked);
    sr = 0;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      lk += int'(Locked);
      sr += int'(sm_reset);
    end
    chk({tag, "_locked_cycles"}, lk, 16);
    chk({tag, "_sm_reset_pulses"}, sr, 1);
    chk({tag, "_fail_after"}, int'(fail_cnt), 0);
    $display("lockout %s locked=%0d sm_reset=%0d fail=%0d", tag, lk, sr, fail_cnt);
  endtask

  // Random bounce on BtnU ending at lvl; U must hold then follow after LAT cycles.
  task automatic bounce_to(input logic lvl, input int idx);
    int nb;
    int bad;
    int lat;
    nb = $urandom_range(0, 3);
    bad = 0;
    for (int i = 0; i < nb; i++) begin
      BtnU = lvl;
      for (int k = $urandom_range(1, 3); k > 0; k--) begin
        tick(1);
        if (U != ~lvl) bad++;
      end
      BtnU = ~lvl;
      for (int k = $urandom_range(1, 3); k > 0; k--) begin
        tick(1);
        if (U != ~lvl) bad++;
      end
    end
    chk("rand_bounce_hold", bad, 0);
    BtnU = lvl;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (U == lvl && lat < 0) lat = k;
    end
    chk("rand_bounce_latency", lat, LAT);
    $display("bounce %0d lvl=%0d bounces=%0d latency=%0d", idx, lvl, nb, lat);
  endtask

  initial begin
    int rises, at, lat, sr, lk, m, op, exp_idle;
    logic prev_u;

    //            bu  bz  qb  qo  hold eu  ez  ec  el  ef
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,10,1'b0,1'b0,1'b0,1'b0,0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,10,1'b1,1'b0,1'b0,1'b0,0};
    vecs[2]  = '{1'b1,1'b1,1'b0,1'b0,20,1'b0,1'b0,1'b1,1'b0,0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,10,1'b1,1'b0,1'b0,1'b0,0};
    vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,10,1'b0,1'b1,1'b0,1'b0,0};
    vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,10,1'b0,1'b0,1'b0,1'b0,0};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b0, 3,1'b0,1'b0,1'b0,1'b0,1};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b0, 2,1'b0,1'b0,1'b0,1'b0,1};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b0, 2,1'b0,1'b0,1'b0,1'b0,2};
    vecs[9]  = '{1'b0,1'b0,1'b0,1'b1, 2,1'b0,1'b0,1'b0,1'b0,0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 2,1'b0,1'b0,1'b0,1'b0,0};
    vecs[11] = '{1'b0,1'b0,1'b1,1'b0, 2,1'b0,1'b0,1'b0,1'b0,1};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b0, 2,1'b0,1'b0,1'b0,1'b0,1};
    vecs[13] = '{1'b0,1'b0,1'b1,1'b1, 2,1'b0,1'b0,1'b0,1'b0,0};
    vecs[14] = '{1'b0,1'b0,1'b0,1'b0, 2,1'b0,1'b0,1'b0,1'b0,0};

    // Reset state, with inputs active to show they are ignored.
    BtnU = 1'b1;
    q_Bad = 1'b1;
    tick(3);
    chk("reset_U", int'(U), 0);
    chk("reset_Z", int'(Z), 0);
    chk("reset_sm_reset", int'(sm_reset), 0);
    chk("reset_Locked", int'(Locked), 0);
    chk("reset_Conflict", int'(Conflict), 0);
    chk("reset_fail_cnt", int'(fail_cnt), 0);
    BtnU = 1'b0;
    q_Bad = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 15; i++) begin
      BtnU = vecs[i].bu;
      BtnZ = vecs[i].bz;
      q_Bad = vecs[i].qb;
      q_Opening = vecs[i].qo;
      tick(vecs[i].hold);
      chk("vec_U", int'(U), int'(vecs[i].eu));
      chk("vec_Z", int'(Z), int'(vecs[i].ez));
      chk("vec_Conflict", int'(Conflict), int'(vecs[i].ec));
      chk("vec_Locked", int'(Locked), int'(vecs[i].el));
      chk("vec_fail_cnt", int'(fail_cnt), vecs[i].ef);
      $display("vec %0d U=%0d Z=%0d C=%0d L=%0d fail=%0d", i, U, Z, Conflict, Locked, fail_cnt);
    end

    // Three one-cycle bounces then stable high: one U rise, LAT after the last edge.
    rises = 0;
    at = -1;
    prev_u = U;
    for (int k = 0; k < 6; k++) begin
      BtnU = (k % 2 == 0);
      tick(1);
      if (U && !prev_u) rises++;
      prev_u = U;
    end
    BtnU = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (U && !prev_u) begin
        rises++;
        if (at < 0) at = k;
      end
      prev_u = U;
    end
    chk("bounce_rises", rises, 1);
    chk("bounce_latency", at, LAT);
    $display("bounce3 rises=%0d latency=%0d", rises, at);
    BtnU = 1'b0;
    tick(10);
    chk("bounce_release_U", int'(U), 0);

    // Both held, then release the "0" button.
    BtnU = 1'b1;
    BtnZ = 1'b1;
    tick(20);
    chk("both_Conflict", int'(Conflict), 1);
    chk("both_U", int'(U), 0);
    chk("both_Z", int'(Z), 0);
    BtnZ = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      if (U && lat < 0) lat = k;
    end
    chk("conflict_release_latency", lat, LAT);
    chk("conflict_release_Conflict", int'(Conflict), 0);
    $display("conflict release latency=%0d", lat);
    BtnU = 1'b0;
    tick(10);

    // Full lockout with a button held across it.
    pulse(1'b1, 1'b0);
    chk("lock_fail1", int'(fail_cnt), 1);
    pulse(1'b1, 1'b0);
    chk("lock_fail2", int'(fail_cnt), 2);
    pulse(1'b1, 1'b0);
    chk("lock_fail3", int'(fail_cnt), 3);
    BtnU = 1'b1;
    expect_lockout("directed");
    tick(10);
    chk("held_after_clear_U", int'(U), 0);
    BtnU = 1'b0;
    tick(10);
    BtnU = 1'b1;
    tick(10);
    chk("repress_after_clear_U", int'(U), 1);
    BtnU = 1'b0;
    tick(10);

    // Reset five cycles into lockout.
    for (int k = 0; k < 3; k++) pulse(1'b1, 1'b0);
    chk("pre_reset_Locked", int'(Locked), 1);
    tick(4);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_Locked", int'(Locked), 0);
    chk("async_reset_fail_cnt", int'(fail_cnt), 0);
    tick(1);
    reset = 1'b0;
    sr = 0;
    lk = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      sr += int'(sm_reset);
      lk += int'(Locked);
    end
    chk("abandoned_sm_reset", sr, 0);
    chk("abandoned_Locked", lk, 0);
    $display("reset mid-lockout sm_reset=%0d locked=%0d", sr, lk);

    // One press then a long idle stretch.
`ifdef NUMLOCK_CTRL_IDLE_ABORT_EN
    exp_idle = 1;
`else
    exp_idle = 0;
`endif
    BtnU = 1'b1;
    tick(10);
    BtnU = 1'b0;
    sr = 0;
    for (int k = 0; k < 60; k++) begin
      tick(1);
      sr += int'(sm_reset);
    end
    chk("idle_sm_reset_pulses", sr, exp_idle);
    $display("idle sm_reset=%0d", sr);

    // Randomized bounce patterns on BtnU.
    for (int r = 0; r < 4; r++) begin
      bounce_to(1'b1, r);
      bounce_to(1'b0, r);
    end

    // Randomized Bad/Opening traffic against a counting model.
    m = int'(fail_cnt);
    for (int r = 0; r < 40; r++) begin
      op = $urandom_range(0, 3);
      case (op)
        0, 1: begin
          pulse(1'b1, 1'b0);
          m = (m < MAXF) ? m + 1 : m;
        end
        2: begin
          pulse(1'b0, 1'b1);
          m = 0;
        end
        default: begin
          pulse(1'b1, 1'b1);
          m = 0;
        end
      endcase
      chk("rand_fail_cnt", int'(fail_cnt), m);
      $display("op %0d kind=%0d fail=%0d model=%0d", r, op, fail_cnt, m);
      if (m == MAXF) begin
        expect_lockout("random");
        m = 0;
      end
      tick($urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ee354_numlock_ctrl.md
EE354_NUMLOCK_CTRL -- requirements
Module: ee354_numlock_ctrl

Interface
REQ-001 SHALL have parameter DEB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (1..255).
REQ-002 SHALL have parameter MAX_FAILS, 3, number of Bad entries that triggers lockout (1..7).
REQ-003 SHALL have parameter LOCKOUT_CYCLES, 16, lockout duration in clock cycles (1..65535).
REQ-004 SHALL have parameter IDLE_CYCLES, 32, idle-abort timeout in cycles; used only with the REQ-029 macro (1..65535).
REQ-005 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port BtnU  input  1  raw, asynchronous "1" button.
REQ-008 SHALL have port BtnZ  input  1  raw, asynchronous "0" button.
REQ-009 SHALL have port q_Bad  input  1  numlock SM status, high while in Bad.
REQ-010 SHALL have port q_Opening  input  1  numlock SM status, high while in Opening.
REQ-011 SHALL have port U  output  1  conditioned "1" level to the numlock SM.
REQ-012 SHALL have port Z  output  1  conditioned "0" level to the numlock SM.
REQ-013 SHALL have port sm_reset  output  1  one-cycle reset pulse to the numlock SM.
REQ-014 SHALL have port Locked  output  1  high while lockout is in force.
REQ-015 SHALL have port Conflict  output  1  high while both debounced buttons are high.
REQ-016 SHALL have port fail_cnt  output  3  current count of Bad entries.

Function
REQ-017 SHALL pass each raw button through a 2-flop synchronizer, then a per-button debouncer whose output changes only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any bounce restarts the count.
REQ-018 SHALL drive U = dbU & ~dbZ and Z = dbZ & ~dbU, registered, only in state RUN; both are 0 in LOCKOUT and CLEAR.
REQ-019 SHALL drive Conflict = dbU & dbZ in every state; while it is high, U and Z are 0.
REQ-020 SHALL detect a q_Bad rising edge with a 1-cycle registered copy and increment fail_cnt, saturating at MAX_FAILS.
REQ-021 SHALL clear fail_cnt to 0 on a q_Opening rising edge; a simultaneous q_Bad rising edge is ignored (clear wins).
REQ-022 SHALL use states RUN, LOCKOUT and CLEAR.
REQ-023 SHALL leave RUN for LOCKOUT on the cycle after fail_cnt reaches MAX_FAILS, loading lock_cnt with LOCKOUT_CYCLES-1; Locked is 1 throughout LOCKOUT.
REQ-024 SHALL decrement lock_cnt in LOCKOUT, ignore q_Bad and q_Opening there, and go to CLEAR when lock_cnt is 0, so LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
REQ-025 SHALL assert sm_reset for exactly one cycle in CLEAR, clear fail_cnt, and return to RUN; a button still held on return is not passed to U/Z until it is debounced low and pressed again.
REQ-026 SHALL assert no output combinationally from BtnU or BtnZ; the latency from a clean edge on BtnU/BtnZ to U/Z is 2 + DEB_CYCLES + 1 cycles.

Reset
REQ-027 SHALL, while reset is high, force state RUN; U, Z, sm_reset, Locked and Conflict to 0; fail_cnt, lock_cnt, debouncers and synchronizers to 0, independent of Clk.
REQ-028 SHALL abandon a lockout in progress on reset mid-operation; no sm_reset pulse is emitted for it.

Configuration
REQ-029 SHALL, when NUMLOCK_CTRL_IDLE_ABORT_EN is defined, count RUN cycles with both debounced buttons low since the last debounced press; after IDLE_CYCLES such cycles, with at least one press since the last sm_reset, it passes through CLEAR (sm_reset pulse, fail_cnt unchanged). Without the macro there is no idle counter and sm_reset occurs only via LOCKOUT.

Verification
REQ-030 SHALL cover: BtnU bouncing 3 times at 1-cycle intervals, then stable high for 10 cycles with DEB_CYCLES=4 -> exactly one U rise, 7 cycles after the last edge.
REQ-031 SHALL cover: BtnU and BtnZ held high together for 20 cycles -> Conflict=1, U=Z=0; release of BtnZ -> U=1 after the debounce latency.
REQ-032 SHALL cover: 3 q_Bad rising edges with MAX_FAILS=3, LOCKOUT_CYCLES=16 -> fail_cnt steps 1,2,3, Locked=1 for 16 cycles, one sm_reset pulse, fail_cnt=0.
REQ-033 SHALL cover: 2 q_Bad edges, then a q_Opening edge -> fail_cnt=0, no lockout; q_Bad and q_Opening rising in the same cycle -> fail_cnt=0.
REQ-034 SHALL cover: reset asserted 5 cycles into LOCKOUT -> Locked=0 immediately, no sm_reset pulse, state RUN.
REQ-035 SHALL cover: with NUMLOCK_CTRL_IDLE_ABORT_EN and IDLE_CYCLES=32, one press then 32 idle cycles -> one sm_reset pulse; without the macro -> no pulse.
